gppcu_dispatch: RTL and testbench
=================================

# gppcu_dispatch

Instruction dispatcher directly upstream of the GPPCU core. Holds a host-loaded program in a local RAM. On a start command, streams the program to the core's instruction port over a valid/ready handshake, repeating it a programmable number of times. Signals completion with a one-cycle done pulse.

## Interface
Parameters:
- DBW, 32, instruction width; matches the core's instruction bus.
- PBW, 8, program address bits; RAM depth is 2^PBW.
- LBW, 16, loop-count width.

Ports:
- iACLK  in  1  clock; the single clock for the block and the core.
- iRST  in  1  reset, synchronous, active-high.
- iPROG_WR  in  1  host program write strobe; honoured only in IDLE.
- iPROG_ADDR  in  PBW  host write address.
- iPROG_WDATA  in  DBW  host write data.
- iSTART  in  1  start request; honoured only in IDLE.
- iPROG_LEN  in  PBW+1  number of instructions, 0..2^PBW; sampled on accepted iSTART.
- iLOOP_CNT  in  LBW  program repetitions; 0 is treated as 1; sampled on accepted iSTART.
- iABORT  in  1  cancel a running program.
- oINSTR  out  DBW  instruction to the core (core iINSTR).
- oINSTR_VALID  out  1  instruction valid (core iINSTR_VALID).
- iINSTR_READY  in  1  core ready (core oINSTR_READY).
- oBUSY  out  1  high in any state other than IDLE.
- oDONE  out  1  one-cycle pulse when the final instruction has been accepted.
- oPC  out  PBW  address of the instruction currently offered.
- oLOOP_REM  out  LBW  iterations remaining, including the current one.

## Operation
- A transfer ("fire") occurs on a cycle where oINSTR_VALID and iINSTR_READY are both high.
- States: IDLE, PRIME, RUN, FIN.
  - IDLE: accepts host writes. On iSTART, latches len and loops. If len is 0, goes to FIN. Otherwise goes to PRIME with pc=0.
  - PRIME: RAM read of address 0 is in flight; oINSTR_VALID=0. Always goes to RUN.
  - RUN: oINSTR_VALID=1 and oINSTR = RAM read data.
    - On fire with pc==len-1 and loop_rem==1: go to FIN.
    - On fire with pc==len-1 otherwise: pc wraps to 0 and loop_rem decrements.
    - On fire with pc<len-1: pc increments.
  - FIN: oDONE=1 for one cycle, then IDLE.
- RAM read address is next_pc when fire is high, otherwise pc. This gives zero-bubble back-to-back dispatch.
- While !iINSTR_READY, oINSTR and oPC are held stable.
- iABORT in PRIME or RUN: next state is IDLE, valid drops without a transfer, and no oDONE. This is the only case where valid may fall unaccepted. In IDLE or FIN, iABORT is ignored.
- iPROG_WR or iSTART outside IDLE: ignored; the RAM is not modified.
- iSTART and iPROG_WR in the same IDLE cycle: the write completes and the start is accepted. The new word is visible if its address is 0, because PRIME re-reads.
- iRST has priority over everything.
  - Outputs after reset: state=IDLE, oINSTR_VALID=0, oBUSY=0, oDONE=0, oPC=0, oLOOP_REM=0.
  - oINSTR after reset is a don't-care; the bench compares it only while valid.
  - RAM contents are not cleared.

## Timing
- iSTART sampled at edge N: PRIME during cycle N+1, first oINSTR_VALID in cycle N+2.
- Throughput: one instruction per cycle while ready is held high.
- Dispatch duration: len×loops fires after the first valid.
- oDONE is asserted the cycle after the final fire; IDLE (oBUSY=0) follows the cycle after that.
- len=0: oDONE is asserted in cycle N+1 and no valid is ever asserted.
- A new iSTART can be accepted on the first IDLE cycle.
- Loop arithmetic:
  - loop_rem is LBW wide, unsigned, with no wrap; 0 is never reached in RUN.
  - len is compared as PBW+1 bits; len=2^PBW uses every address and pc wraps from all-ones to 0.

## Structure
- Add DBW, PBW, LBW defaults and the state encodings (2-bit: IDLE=0, PRIME=1, RUN=2, FIN=3) to GPPCU_PARAMETERS.vh.
- One sub-module: gppcu_prog_ram.
  - Simple dual-port RAM: write port plus synchronous read port, registered output, read-during-write to the same address unspecified.
  - Infers block RAM.
- The FSM, counters and address mux live in gppcu_dispatch.

## Test plan
- Load 0..3 with 0xA0..0xA3; start with len=4, loops=2, ready held high. Expect 8 consecutive valid cycles from cycle N+2, data A0,A1,A2,A3,A0,…,A3, then oDONE, then oBUSY=0.
- Same program; ready toggles 1,0,0,1,… Expect oINSTR and oPC stable while ready=0, no instruction skipped or duplicated, and 8 accepted words in total.
- len=0, loops=5. Expect oDONE in cycle N+1 and oINSTR_VALID never high.
- loops=0, len=2. Expect exactly 2 transfers (treated as 1 loop).
- Assert iABORT after the 3rd fire. Expect valid=0 and oBUSY=0 next cycle with no oDONE. A following start with len=1 dispatches word 0.
- During RUN, iPROG_WR to address 1 with 0xFF. Expect RAM unchanged, so the second loop still delivers A1. Also assert iRST mid-RUN and expect all outputs at their reset values next cycle.

Source files
------------

// File: rtl/gppcu_dispatch_pkg.sv
// Shared defaults and state encoding for the GPPCU instruction dispatcher.
package gppcu_dispatch_pkg;

  localparam int DBW_DEF = 32;
  localparam int PBW_DEF = 8;
  localparam int LBW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } disp_state_t;

endpackage

// File: rtl/gppcu_dispatch_prog_ram.sv
// Program store: simple dual-port RAM, one write port, registered synchronous read.
module gppcu_prog_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/gppcu_dispatch.sv
// Streams a host-loaded program to the GPPCU core over valid/ready, repeating it
// a programmable number of times, with a one-cycle done pulse at the end.
module gppcu_dispatch
  import gppcu_dispatch_pkg::*;
#(
  parameter int DBW = DBW_DEF,
  parameter int PBW = PBW_DEF,
  parameter int LBW = LBW_DEF
) (
  input  logic           iACLK,
  input  logic           iRST,
  input  logic           iPROG_WR,
  input  logic [PBW-1:0] iPROG_ADDR,
  input  logic [DBW-1:0] iPROG_WDATA,
  input  logic           iSTART,
  input  logic [PBW:0]   iPROG_LEN,
  input  logic [LBW-1:0] iLOOP_CNT,
  input  logic           iABORT,
  output logic [DBW-1:0] oINSTR,
  output logic           oINSTR_VALID,
  input  logic           iINSTR_READY,
  output logic           oBUSY,
  output logic           oDONE,
  output logic [PBW-1:0] oPC,
  output logic [LBW-1:0] oLOOP_REM
);

  disp_state_t    state, state_next;
  logic [PBW-1:0] pc, pc_next;
  logic [PBW:0]   len, len_next;
  logic [LBW-1:0] loop_rem, loop_next;
  logic [PBW:0]   len_m1;
  logic           fire, last, ram_wr;
  logic [PBW-1:0] rd_addr;

  assign len_m1 = len - 1'b1;
  assign last   = ({1'b0, pc} == len_m1);
  assign fire   = (state == RUN) && iINSTR_READY && !iABORT;
  assign ram_wr = iPROG_WR && (state == IDLE);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    len_next   = len;
    loop_next  = loop_rem;
    case (state)
      IDLE: begin
        if (iSTART) begin
          len_next   = iPROG_LEN;
          loop_next  = (iLOOP_CNT == '0) ? LBW'(1) : iLOOP_CNT;
          pc_next    = '0;
          state_next = (iPROG_LEN == '0) ? FIN : PRIME;
        end
      end
      PRIME: begin
        state_next = iABORT ? IDLE : RUN;
      end
      RUN: begin
        if (iABORT) begin
          state_next = IDLE;
          pc_next    = '0;
        end else if (fire) begin
          if (last) begin
            pc_next = '0;
            if (loop_rem == LBW'(1)) state_next = FIN;
            else                     loop_next  = loop_rem - LBW'(1);
          end else begin
            pc_next = pc + PBW'(1);
          end
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reading next_pc on fire pre-fetches the following word so RUN has no bubbles;
  // otherwise re-reading pc keeps oINSTR stable while the core stalls.
  assign rd_addr = fire ? pc_next : pc;

  always_ff @(posedge iACLK) begin
    if (iRST) begin
      state    <= IDLE;
      pc       <= '0;
      len      <= '0;
      loop_rem <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      len      <= len_next;
      loop_rem <= loop_next;
    end
  end

  gppcu_prog_ram #(
    .DW(DBW),
    .AW(PBW)
  ) u_ram (
    .clk     (iACLK),
    .wr_en   (ram_wr),
    .wr_addr (iPROG_ADDR),
    .wr_data (iPROG_WDATA),
    .rd_addr (rd_addr),
    .rd_data (oINSTR)
  );

  assign oINSTR_VALID = (state == RUN);
  assign oBUSY        = (state != IDLE);
  assign oDONE        = (state == FIN);
  assign oPC          = pc;
  assign oLOOP_REM    = loop_rem;

endmodule

// File: tb/tb_gppcu_dispatch.sv
// Bench for gppcu_dispatch: table-driven scenarios, hand-written corner sequences
// and randomized runs checked against an expected-instruction-stream model.
module tb_gppcu_dispatch;

  localparam int DBW = 32;
  localparam int PBW = 8;
  localparam int LBW = 16;
  localparam int BUDGET = 4000;

  logic           clk;
  logic           iRST, iPROG_WR, iSTART, iABORT, iINSTR_READY;
  logic [PBW-1:0] iPROG_ADDR;
  logic [DBW-1:0] iPROG_WDATA;
  logic [PBW:0]   iPROG_LEN;
  logic [LBW-1:0] iLOOP_CNT;
  logic [DBW-1:0] oINSTR;
  logic           oINSTR_VALID, oBUSY, oDONE;
  logic [PBW-1:0] oPC;
  logic [LBW-1:0] oLOOP_REM;

  int checks = 0;
  int failures = 0;
  logic [DBW-1:0] prog [256];

  gppcu_dispatch #(
    .DBW(DBW),
    .PBW(PBW),
    .LBW(LBW)
  ) dut (
    .iACLK        (clk),
    .iRST         (iRST),
    .iPROG_WR     (iPROG_WR),
    .iPROG_ADDR   (iPROG_ADDR),
    .iPROG_WDATA  (iPROG_WDATA),
    .iSTART       (iSTART),
    .iPROG_LEN    (iPROG_LEN),
    .iLOOP_CNT    (iLOOP_CNT),
    .iABORT       (iABORT),
    .oINSTR       (oINSTR),
    .oINSTR_VALID (oINSTR_VALID),
    .iINSTR_READY (iINSTR_READY),
    .oBUSY        (oBUSY),
    .oDONE        (oDONE),
    .oPC          (oPC),
    .oLOOP_REM    (oLOOP_REM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All tasks start and end at a negedge, with inputs free to be driven.
  task automatic wr(input int a, input logic [DBW-1:0] d);
    iPROG_WR    = 1'b1;
    iPROG_ADDR  = PBW'(a);
    iPROG_WDATA = d;
    prog[a]     = d;
    @(negedge clk);
    iPROG_WR    = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(oINSTR_VALID), 64'(0));
    chk({tag, "_busy"},  64'(oBUSY), 64'(0));
    chk({tag, "_done"},  64'(oDONE), 64'(0));
  endtask

  // rmode: 0 ready held high, 1 pattern 1,0,0 repeating, 2 random.
  task automatic run(input int len, input int loops, input int rmode, input int abort_after,
                     input bit wr_run, input bit wr_start, output int nf);
    int  eff;
    int  total;
    int  cyc;
    bit  r;
    bit  aborting;
    eff   = (loops == 0) ? 1 : loops;
    total = len * eff;
    nf    = 0;
    iSTART    = 1'b1;
    iPROG_LEN = (PBW+1)'(len);
    iLOOP_CNT = LBW'(loops);
    if (wr_start) begin
      iPROG_WR    = 1'b1;
      iPROG_ADDR  = '0;
      iPROG_WDATA = $urandom;
      prog[0]     = iPROG_WDATA;
    end
    @(negedge clk);
    iSTART   = 1'b0;
    iPROG_WR = 1'b0;
    if (len == 0) begin
      chk("len0_done",  64'(oDONE), 64'(1));
      chk("len0_valid", 64'(oINSTR_VALID), 64'(0));
      @(negedge clk);
      chk_idle("len0_after");
      return;
    end
    chk("prime_valid", 64'(oINSTR_VALID), 64'(0));
    chk("prime_busy",  64'(oBUSY), 64'(1));
    cyc = 0;
    while (nf < total && cyc < BUDGET) begin
      @(negedge clk);
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom % 2);
      endcase
      aborting = (abort_after >= 0) && (nf == abort_after);
      if (aborting) r = 1'b0;
      iINSTR_READY = r;
      iABORT       = aborting;
      if (wr_run && cyc == 0) begin
        iPROG_WR    = 1'b1;
        iPROG_ADDR  = PBW'(1);
        iPROG_WDATA = 32'hFF;
      end else begin
        iPROG_WR    = 1'b0;
      end
      chk("run_valid", 64'(oINSTR_VALID), 64'(1));
      chk("run_done",  64'(oDONE), 64'(0));
      chk("run_instr", 64'(oINSTR), 64'(prog[nf % len]));
      chk("run_pc",    64'(oPC), 64'(nf % len));
      chk("run_loop",  64'(oLOOP_REM), 64'(eff - nf / len));
      if (aborting) begin
        @(negedge clk);
        iABORT = 1'b0;
        chk_idle("abort");
        return;
      end
      if (r) nf++;
      cyc++;
    end
    if (cyc >= BUDGET) chk("run_timeout", 64'(cyc), 64'(total));
    @(negedge clk);
    iPROG_WR = 1'b0;
    chk("fin_done",  64'(oDONE), 64'(1));
    chk("fin_valid", 64'(oINSTR_VALID), 64'(0));
    chk("fin_busy",  64'(oBUSY), 64'(1));
    @(negedge clk);
    chk_idle("post_fin");
    chk("post_fin_pc", 64'(oPC), 64'(0));
  endtask

  typedef struct {
    int len;
    int loops;
    int rmode;
    int abort_after;
    bit wr_run;
    bit wr_start;
    int exp_fires;
  } vec_t;

  initial begin
    vec_t vecs [8];
    int   nf;
    int   len;
    int   loops;

    vecs[0] = '{4,   2, 0, -1, 1'b0, 1'b0, 8};
    vecs[1] = '{4,   2, 1, -1, 1'b0, 1'b0, 8};
    vecs[2] = '{0,   5, 0, -1, 1'b0, 1'b0, 0};
    vecs[3] = '{2,   0, 0, -1, 1'b0, 1'b0, 2};
    vecs[4] = '{4,   2, 0,  3, 1'b0, 1'b0, 3};
    vecs[5] = '{1,   1, 0, -1, 1'b0, 1'b0, 1};
    vecs[6] = '{4,   2, 1, -1, 1'b1, 1'b0, 8};
    vecs[7] = '{256, 2, 2, -1, 1'b0, 1'b0, 512};

    iRST = 1'b1; iPROG_WR = 1'b0; iSTART = 1'b0; iABORT = 1'b0; iINSTR_READY = 1'b0;
    iPROG_ADDR = '0; iPROG_WDATA = '0; iPROG_LEN = '0; iLOOP_CNT = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_pc",   64'(oPC), 64'(0));
    chk("reset_loop", 64'(oLOOP_REM), 64'(0));
    iRST = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 256; i++) wr(i, $urandom);
    for (int i = 0; i < 4; i++) wr(i, 32'hA0 + i);

    foreach (vecs[i]) begin
      run(vecs[i].len, vecs[i].loops, vecs[i].rmode, vecs[i].abort_after,
          vecs[i].wr_run, vecs[i].wr_start, nf);
      chk($sformatf("transfers_v%0d", i), 64'(nf), 64'(vecs[i].exp_fires));
    end

    // Reset in the middle of a run.
    iINSTR_READY = 1'b1;
    iSTART = 1'b1; iPROG_LEN = 9'd4; iLOOP_CNT = 16'd3;
    @(negedge clk);
    iSTART = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_valid", 64'(oINSTR_VALID), 64'(1));
    iRST = 1'b1;
    @(negedge clk);
    chk_idle("midrun_reset");
    chk("midrun_reset_pc",   64'(oPC), 64'(0));
    chk("midrun_reset_loop", 64'(oLOOP_REM), 64'(0));
    iRST = 1'b0;

    for (int t = 0; t < 24; t++) begin
      wr($urandom_range(0, 15), $urandom);
      wr($urandom_range(0, 15), $urandom);
      len   = ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, 12));
      loops = int'($urandom_range(0, 3));
      run(len, loops, 2, -1, 1'($urandom % 2), 1'($urandom % 2), nf);
      chk("rand_transfers", 64'(nf), 64'(len * ((loops == 0) ? 1 : loops)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
